// File: rtl/fifo_push_rr_arbiter.sv
// Round-robin push-side arbiter for a shared FIFO. A requester keeps the grant until its last beat moves.
// Optional per-requester saturating beat counters: define ARB_BEAT_CNT_EN.
module fifo_push_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_push_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
`ifdef ARB_BEAT_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0]         beat_cnt_o
`endif
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] arb_winner;
    logic             arb_found;
    logic             pkt_end;

    // Search ptr+1, ptr+2, ... so the last-served requester gets the lowest priority.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        arb_found  = 1'b0;
        arb_winner = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!arb_found && req_valid_i[cand]) begin
                arb_found  = 1'b1;
                arb_winner = cand;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        fifo_push_o = 1'b0;
        fifo_data_o = '0;
        if (state == LOCKED) begin
            req_ready_o[owner] = ~fifo_full_i;
            fifo_push_o        = req_valid_i[owner] & ~fifo_full_i;
            fifo_data_o        = req_data_i[owner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign pkt_end = fifo_push_o & req_last_i[owner];

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state   <= IDLE;
            grant_o <= '0;
            busy_o  <= 1'b0;
            ptr     <= IDX_W'(NUM_REQ - 1);
            owner   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        state   <= LOCKED;
                        grant_o <= NUM_REQ'(1) << arb_winner;
                        busy_o  <= 1'b1;
                        owner   <= arb_winner;
                    end
                end
                LOCKED: begin
                    if (pkt_end) begin
                        state   <= IDLE;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        ptr     <= owner;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_BEAT_CNT_EN
    logic [15:0] beat_cnt [NUM_REQ];

    always_ff @(posedge clk_i) begin
        // NOTE: the counter array is software-visible, so every entry is explicitly cleared on reset.
        if (!rst_ni) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                beat_cnt[k] <= '0;
            end
        end else if (fifo_push_o && (beat_cnt[owner] != 16'hFFFF)) begin
            beat_cnt[owner] <= beat_cnt[owner] + 16'd1;
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt_out
        assign beat_cnt_o[k*16 +: 16] = beat_cnt[k];
    end
`endif

endmodule

// File: tb/tb_fifo_push_rr_arbiter.sv
// Directed bench for fifo_push_rr_arbiter: arbitration order, packet lock, FIFO-full stall, reset.
// Counter saturation is exercised when ARB_BEAT_CNT_EN is defined.
module tb_fifo_push_rr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_push;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;
`ifdef ARB_BEAT_CNT_EN
    logic [NUM_REQ*16-1:0]         beat_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fifo_push_rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .fifo_full_i (fifo_full),
        .fifo_push_o (fifo_push),
        .fifo_data_o (fifo_data),
        .grant_o     (grant),
        .busy_o      (busy)
`ifdef ARB_BEAT_CNT_EN
        ,
        .beat_cnt_o  (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic l, input logic [7:0] d);
        req_valid[k]           = v;
        req_last[k]            = l;
        req_data[k*8 +: 8]     = d;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_push"},  32'(fifo_push), 32'h0);
        check({tag, "_busy"},  32'(busy), 32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        // Reset state
        cyc();
        cyc();
        #2;
        check_idle("reset");
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_data",  32'(fifo_data), 32'h0);
`ifdef ARB_BEAT_CNT_EN
        check("reset_cnt", {31'b0, |beat_cnt}, 32'h0);
`endif

        // Idle for 5 cycles with no requests
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            #2;
            check_idle($sformatf("idle%0d", c));
        end

        // Req0 three-beat packet
        cyc();
        set_req(0, 1'b1, 1'b0, 8'h11);
        #2;
        check("p3_arb_grant", 32'(grant), 32'h0);
        check("p3_arb_ready", 32'(req_ready), 32'h0);
        cyc();
        #2;
        check("p3_b0_grant", 32'(grant), 32'h1);
        check("p3_b0_busy",  32'(busy), 32'h1);
        check("p3_b0_ready", 32'(req_ready), 32'h1);
        check("p3_b0_push",  32'(fifo_push), 32'h1);
        check("p3_b0_data",  32'(fifo_data), 32'h11);
        cyc();
        set_req(0, 1'b1, 1'b0, 8'h22);
        #2;
        check("p3_b1_push", 32'(fifo_push), 32'h1);
        check("p3_b1_data", 32'(fifo_data), 32'h22);
        cyc();
        set_req(0, 1'b1, 1'b1, 8'h33);
        #2;
        check("p3_b2_push", 32'(fifo_push), 32'h1);
        check("p3_b2_data", 32'(fifo_data), 32'h33);
        cyc();
        set_req(0, 1'b0, 1'b0, 8'h00);
        #2;
        check_idle("p3_end");
`ifdef ARB_BEAT_CNT_EN
        check("p3_cnt0", 32'(beat_cnt[15:0]), 32'd3);
`endif

        // Fresh reset, then all four requesters hold single-beat packets
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b1, 1'b1, 8'(8'hA0 + k));
        #2;
        check("rr_c0_grant", 32'(grant), 32'h0);
        for (int c = 1; c < 10; c++) begin
            cyc();
            #2;
            if (c % 2 == 0) begin
                check($sformatf("rr_c%0d_grant", c), 32'(grant), 32'h0);
                check($sformatf("rr_c%0d_push", c),  32'(fifo_push), 32'h0);
            end else begin
                check($sformatf("rr_c%0d_grant", c), 32'(grant), 32'(1 << ((c / 2) % 4)));
                check($sformatf("rr_c%0d_push", c),  32'(fifo_push), 32'h1);
                check($sformatf("rr_c%0d_data", c),  32'(fifo_data), 32'(8'hA0 + (c / 2) % 4));
            end
        end

        // Req2 packet stalled by a full FIFO for 4 cycles (pointer now at 0)
        cyc();
        req_valid = '0;
        req_last  = '0;
        set_req(2, 1'b1, 1'b0, 8'h51);
        #2;
        check("full_arb_grant", 32'(grant), 32'h0);
        cyc();
        #2;
        check("full_b0_grant", 32'(grant), 32'h4);
        check("full_b0_data",  32'(fifo_data), 32'h51);
        check("full_b0_push",  32'(fifo_push), 32'h1);
        cyc();
        set_req(2, 1'b1, 1'b0, 8'h52);
        fifo_full = 1'b1;
        #2;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                cyc();
                #2;
            end
            check($sformatf("full_s%0d_push", c),  32'(fifo_push), 32'h0);
            check($sformatf("full_s%0d_ready", c), 32'(req_ready), 32'h0);
            check($sformatf("full_s%0d_grant", c), 32'(grant), 32'h4);
        end
        cyc();
        fifo_full = 1'b0;
        #2;
        check("full_b1_push",  32'(fifo_push), 32'h1);
        check("full_b1_data",  32'(fifo_data), 32'h52);
        check("full_b1_ready", 32'(req_ready), 32'h4);
        cyc();
        set_req(2, 1'b1, 1'b1, 8'h53);
        #2;
        check("full_b2_push", 32'(fifo_push), 32'h1);
        check("full_b2_data", 32'(fifo_data), 32'h53);
        cyc();
        set_req(2, 1'b0, 1'b0, 8'h00);
        #2;
        check_idle("full_end");

        // Req1 owner gaps its valid while req3 waits (pointer now at 2)
        cyc();
        set_req(1, 1'b1, 1'b0, 8'h61);
        #2;
        check("gap_arb_grant", 32'(grant), 32'h0);
        cyc();
        set_req(3, 1'b1, 1'b1, 8'h71);
        #2;
        check("gap_b0_grant", 32'(grant), 32'h2);
        check("gap_b0_data",  32'(fifo_data), 32'h61);
        for (int c = 0; c < 2; c++) begin
            cyc();
            set_req(1, 1'b0, 1'b0, 8'h00);
            #2;
            check($sformatf("gap_h%0d_grant", c), 32'(grant), 32'h2);
            check($sformatf("gap_h%0d_push", c),  32'(fifo_push), 32'h0);
            check($sformatf("gap_h%0d_ready", c), 32'(req_ready), 32'h2);
        end
        cyc();
        set_req(1, 1'b1, 1'b1, 8'h62);
        #2;
        check("gap_b1_grant", 32'(grant), 32'h2);
        check("gap_b1_data",  32'(fifo_data), 32'h62);
        check("gap_b1_push",  32'(fifo_push), 32'h1);
        cyc();
        set_req(1, 1'b0, 1'b0, 8'h00);
        #2;
        check("gap_idle_grant", 32'(grant), 32'h0);
        cyc();
        #2;
        check("gap_r3_grant", 32'(grant), 32'h8);
        check("gap_r3_data",  32'(fifo_data), 32'h71);
        check("gap_r3_push",  32'(fifo_push), 32'h1);
        cyc();
        set_req(3, 1'b0, 1'b0, 8'h00);
        #2;
        check_idle("gap_end");

        // Reset in the middle of a req0 packet (pointer at 3 wraps to 0)
        cyc();
        set_req(0, 1'b1, 1'b0, 8'h81);
        #2;
        check("rst_arb_grant", 32'(grant), 32'h0);
        cyc();
        #2;
        check("rst_b0_grant", 32'(grant), 32'h1);
        cyc();
        rst_n = 1'b0;
        #2;
        check("rst_pre_grant", 32'(grant), 32'h1);
        cyc();
        #2;
        check_idle("rst_post");
        check("rst_post_ready", 32'(req_ready), 32'h0);
`ifdef ARB_BEAT_CNT_EN
        check("rst_cnt", {31'b0, |beat_cnt}, 32'h0);

        // Long packet on req0 to saturate its counter
        rst_n = 1'b1;
        repeat (70010) cyc();
        #2;
        check("sat_cnt0",   32'(beat_cnt[15:0]), 32'hFFFF);
        check("sat_others", {31'b0, |beat_cnt[63:16]}, 32'h0);
        cyc();
        set_req(0, 1'b1, 1'b1, 8'h82);
        cyc();
        set_req(0, 1'b0, 1'b0, 8'h00);
        #2;
        check("sat_cnt0_hold", 32'(beat_cnt[15:0]), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
